layer_mem_arbiter: RTL
======================

# layer_mem_arbiter

Shares the single layer-memory port (crd/cwr/csel/caddr_rd/caddr_wr/cdata_wr/cdata_rd) between two engines. Requester 0 is the convolution write-back engine and writes layer 0. Requester 1 is the max-pooling engine and reads layer 0, then writes layer 1. The block runs round-robin arbitration with an optional lock, so a requester can keep the port for an atomic burst such as a 2x2 pooling read. It also counts completed writes per layer and tells the top-level controller when each layer is complete.

## Interface
- DATA_WIDTH, 20, memory word width
- ADDR_WIDTH, 12, memory address width
- L0_WORDS, 4096, writes that complete layer 0
- L1_WORDS, 1024, writes that complete layer 1
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- reqN  in  1  request from requester N (N = 0, 1); held with its fields until granted
- weN  in  1  1 = write, 0 = read
- selN  in  3  target memory (csel encoding: 001/010 = layer 0, 011/100 = layer 1, 101 = layer 2)
- addrN  in  ADDR_WIDTH  word address
- wdataN  in  DATA_WIDTH  write data
- lockN  in  1  keep ownership after this access
- gntN  out  1  combinational; request accepted at this rising edge when reqN & gntN
- rvalidN  out  1  one-cycle pulse; rdataN valid
- rdataN  out  DATA_WIDTH  read return data
- crd, cwr  out  1  memory read / write strobes
- csel  out  3  memory select
- caddr_rd, caddr_wr  out  ADDR_WIDTH  read / write address
- cdata_wr  out  DATA_WIDTH  write data
- cdata_rd  in  DATA_WIDTH  read data from memory
- l0_done, l1_done  out  1  sticky layer-complete flags
- err  out  1  sticky: a request was accepted with an illegal sel

## Operation
- Only one command is accepted per cycle.
- **Round-robin**
  - Pointer `last` holds the last accepted requester; it resets to 1, so requester 0 wins the first tie.
  - If only one requester has req=1, that requester is granted.
  - If both have req=1, the requester that is not `last` is granted.
- **Lock**
  - An accepted request with lockN=1 makes N the owner.
  - While an owner exists, only the owner can be granted; the other requester waits even if the owner's req is low.
  - Ownership is released when the owner has an accepted request with lockN=0.
- **Command issue (registered)**
  - Accepted write: next cycle cwr=1, csel=selN, caddr_wr=addrN, cdata_wr=wdataN.
  - Accepted read: next cycle crd=1, csel=selN, caddr_rd=addrN.
  - The requester ID is tagged alongside the issued command.
- **Read return**
  - cdata_rd is sampled at the end of the crd cycle.
  - Next cycle: rvalid of the tagged requester = 1 and its rdata = the sampled value. The other requester's rvalid stays 0.
  - rdataN holds its value until its next return.
- **Idle cycle:** crd=cwr=0, csel=000; address and data outputs hold their last values.
- **Illegal sel** (000, 110, 111)
  - The request is granted and consumed, but no strobe is issued and no rvalid is returned.
  - err is set.
- **Layer counters**
  - Layer-0 counter: 13 bits, saturating; increments on each issued write with csel 001/010.
  - Layer-1 counter: 11 bits, saturating; increments on each issued write with csel 011/100.
  - l0_done is set when the layer-0 counter reaches L0_WORDS; l1_done is set when the layer-1 counter reaches L1_WORDS. Both stay set until reset.
  - Reads and layer-2 writes are not counted.

## Timing
- **Reset values:** every output = 0, counters = 0, no owner, `last`=1, pipeline empty.
- **Latency**
  - Grant to memory strobe: 1 cycle.
  - Grant to rvalid: 2 cycles.
  - Full throughput: one access per cycle, back-to-back.
- A write issued in cycle k+1 is counted at the end of k+1; done rises in cycle k+2.
- **Simultaneous events**
  - A grant, an issue of the previous command and a read return can all occur in the same cycle without interference.
  - A read issued the cycle after a write to the same address sees the written data; ordering is the memory's.
- **Reset mid-operation**
  - The issued command is killed immediately (strobes go 0 asynchronously) and any pending rvalid is suppressed.
  - Lock and counters are cleared.
- gntN depends only on reqN, the owner and `last`; it has no combinational path from cdata_rd.

## Test plan
- **Reset then single write:** req0 write sel=001 addr=0x005 data=0x12345 → gnt0 in the same cycle; next cycle cwr=1, csel=001, caddr_wr=0x005, cdata_wr=0x12345; crd=0.
- **Contention:** req0 and req1 both held high for 4 cycles, no lock → grants alternate 0,1,0,1; four back-to-back strobes with csel following each requester's sel.
- **Locked burst:**
  - Stimulus: req1 issues 4 reads of sel=001, addrs 0x000, 0x001, 0x040, 0x041, lock=1,1,1,0, while req0 is held high.
  - Response: gnt0=0 through the burst. rvalid1 pulses 4 times, 2 cycles after each grant, with rdata equal to memory contents. req0 is granted the cycle after the release.
- **Done flags:** 4096 writes of sel=001 → l0_done rises exactly one cycle after the 4096th cwr. 1024 writes of sel=011 → l1_done rises. Reads do not advance either flag.
- **Illegal sel:** request with sel=111 → granted, no crd/cwr, no rvalid, err=1 and sticky.
- **Reset mid-burst:**
  - Stimulus: assert reset during the crd cycle of a locked read.
  - Response: crd drops immediately, no rvalid follows, and the lock is cleared. After release, req0 is granted first.

Source files
------------

// File: rtl/layer_mem_arbiter_if.sv
// rtl/layer_mem_arbiter_if.sv - requester and layer-memory signal bundle for layer_mem_arbiter
interface layer_mem_arbiter_if #(
  parameter int DATA_WIDTH = 20,
  parameter int ADDR_WIDTH = 12
);
  logic                  req0, req1;
  logic                  we0, we1;
  logic [2:0]            sel0, sel1;
  logic [ADDR_WIDTH-1:0] addr0, addr1;
  logic [DATA_WIDTH-1:0] wdata0, wdata1;
  logic                  lock0, lock1;
  logic                  gnt0, gnt1;
  logic                  rvalid0, rvalid1;
  logic [DATA_WIDTH-1:0] rdata0, rdata1;
  logic                  crd, cwr;
  logic [2:0]            csel;
  logic [ADDR_WIDTH-1:0] caddr_rd, caddr_wr;
  logic [DATA_WIDTH-1:0] cdata_wr;
  logic [DATA_WIDTH-1:0] cdata_rd;
  logic                  l0_done, l1_done, err;

  modport slave (
    input  req0, req1, we0, we1, sel0, sel1, addr0, addr1, wdata0, wdata1, lock0, lock1,
    input  cdata_rd,
    output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
    output crd, cwr, csel, caddr_rd, caddr_wr, cdata_wr, l0_done, l1_done, err
  );

  modport master (
    output req0, req1, we0, we1, sel0, sel1, addr0, addr1, wdata0, wdata1, lock0, lock1,
    output cdata_rd,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
    input  crd, cwr, csel, caddr_rd, caddr_wr, cdata_wr, l0_done, l1_done, err
  );
endinterface

// File: rtl/layer_mem_arbiter.sv
// rtl/layer_mem_arbiter.sv - round-robin/lock arbiter for the shared layer-memory port with per-layer write counters
module layer_mem_arbiter #(
  parameter int DATA_WIDTH = 20,
  parameter int ADDR_WIDTH = 12,
  parameter int L0_WORDS   = 4096,
  parameter int L1_WORDS   = 1024
) (
  input logic                clk,
  input logic                reset,
  layer_mem_arbiter_if.slave arb_if
);
  localparam logic [12:0] L0_TGT = 13'(L0_WORDS);
  localparam logic [10:0] L1_TGT = 11'(L1_WORDS);

  logic                  r_last, r_own_vld, r_own_id;
  logic                  r_crd, r_cwr, r_id;
  logic [2:0]            r_csel;
  logic [ADDR_WIDTH-1:0] r_caddr_rd, r_caddr_wr;
  logic [DATA_WIDTH-1:0] r_cdata_wr;
  logic                  r_rvalid0, r_rvalid1;
  logic [DATA_WIDTH-1:0] r_rdata0, r_rdata1;
  logic [12:0]           r_l0_cnt;
  logic [10:0]           r_l1_cnt;
  logic                  r_l0_done, r_l1_done, r_err;

  logic                  w_gnt0, w_gnt1, w_acc, w_id, w_we, w_lock, w_legal;
  logic [2:0]            w_sel;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic                  w_l0_inc, w_l1_inc;
  logic [12:0]           w_l0_nxt;
  logic [10:0]           w_l1_nxt;

  // An owner excludes the other requester even while its own req is low.
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (r_own_vld) begin
      w_gnt0 = arb_if.req0 && !r_own_id;
      w_gnt1 = arb_if.req1 && r_own_id;
    end else begin
      w_gnt0 = arb_if.req0 && (!arb_if.req1 || r_last);
      w_gnt1 = arb_if.req1 && (!arb_if.req0 || !r_last);
    end
  end

  assign w_acc   = w_gnt0 || w_gnt1;
  assign w_id    = w_gnt1;
  assign w_we    = w_id ? arb_if.we1    : arb_if.we0;
  assign w_sel   = w_id ? arb_if.sel1   : arb_if.sel0;
  assign w_addr  = w_id ? arb_if.addr1  : arb_if.addr0;
  assign w_wdata = w_id ? arb_if.wdata1 : arb_if.wdata0;
  assign w_lock  = w_id ? arb_if.lock1  : arb_if.lock0;
  assign w_legal = (w_sel != 3'd0) && (w_sel <= 3'd5);

  assign w_l0_inc = r_cwr && ((r_csel == 3'd1) || (r_csel == 3'd2)) && (r_l0_cnt != '1);
  assign w_l1_inc = r_cwr && ((r_csel == 3'd3) || (r_csel == 3'd4)) && (r_l1_cnt != '1);
  assign w_l0_nxt = r_l0_cnt + {12'd0, w_l0_inc};
  assign w_l1_nxt = r_l1_cnt + {10'd0, w_l1_inc};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_last     <= 1'b1;
      r_own_vld  <= 1'b0;
      r_own_id   <= 1'b0;
      r_crd      <= 1'b0;
      r_cwr      <= 1'b0;
      r_id       <= 1'b0;
      r_csel     <= 3'd0;
      r_caddr_rd <= '0;
      r_caddr_wr <= '0;
      r_cdata_wr <= '0;
      r_rvalid0  <= 1'b0;
      r_rvalid1  <= 1'b0;
      r_rdata0   <= '0;
      r_rdata1   <= '0;
      r_l0_cnt   <= '0;
      r_l1_cnt   <= '0;
      r_l0_done  <= 1'b0;
      r_l1_done  <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_crd  <= 1'b0;
      r_cwr  <= 1'b0;
      r_csel <= 3'd0;
      if (w_acc) begin
        r_last <= w_id;
        if (w_lock) begin
          r_own_vld <= 1'b1;
          r_own_id  <= w_id;
        end else begin
          r_own_vld <= 1'b0;
        end
        if (w_legal) begin
          r_id   <= w_id;
          r_csel <= w_sel;
          if (w_we) begin
            r_cwr      <= 1'b1;
            r_caddr_wr <= w_addr;
            r_cdata_wr <= w_wdata;
          end else begin
            r_crd      <= 1'b1;
            r_caddr_rd <= w_addr;
          end
        end else begin
          r_err <= 1'b1;
        end
      end
      // Read data is captured at the end of the crd cycle and returned to the tagged requester.
      r_rvalid0 <= r_crd && !r_id;
      r_rvalid1 <= r_crd && r_id;
      if (r_crd && !r_id) r_rdata0 <= arb_if.cdata_rd;
      if (r_crd && r_id)  r_rdata1 <= arb_if.cdata_rd;
      r_l0_cnt <= w_l0_nxt;
      r_l1_cnt <= w_l1_nxt;
      if (w_l0_nxt >= L0_TGT) r_l0_done <= 1'b1;
      if (w_l1_nxt >= L1_TGT) r_l1_done <= 1'b1;
    end
  end

  assign arb_if.gnt0     = w_gnt0;
  assign arb_if.gnt1     = w_gnt1;
  assign arb_if.rvalid0  = r_rvalid0;
  assign arb_if.rvalid1  = r_rvalid1;
  assign arb_if.rdata0   = r_rdata0;
  assign arb_if.rdata1   = r_rdata1;
  assign arb_if.crd      = r_crd;
  assign arb_if.cwr      = r_cwr;
  assign arb_if.csel     = r_csel;
  assign arb_if.caddr_rd = r_caddr_rd;
  assign arb_if.caddr_wr = r_caddr_wr;
  assign arb_if.cdata_wr = r_cdata_wr;
  assign arb_if.l0_done  = r_l0_done;
  assign arb_if.l1_done  = r_l1_done;
  assign arb_if.err      = r_err;
endmodule
